// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and helpers for the HI/LO accumulator bank
package hilo_pkg;

    typedef enum logic [2:0] {
        READ_HI  = 3'd0,
        READ_LO  = 3'd1,
        WRITE_HI = 3'd2,
        WRITE_LO = 3'd3,
        ISSUE    = 3'd4
    } hilo_op_e;

    typedef enum logic [1:0] {
        OVERWRITE = 2'd0,
        ADD       = 2'd1,
        SUB       = 2'd2
    } acc_mode_e;

    // A multi-cycle result carries a full {hi, lo} pair.
    function automatic int res_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/hilo_acc_slot.sv
// rtl/hilo_acc_slot.sv - one HI/LO pair with pending bit, mode and commit datapath
module hilo_acc_slot
    import hilo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               issue,
    input  logic [1:0]         issue_mode,
    input  logic               wr_hi,
    input  logic               wr_lo,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               commit,
    input  logic [2*WIDTH-1:0] res_data,
    output logic [WIDTH-1:0]   view_hi,
    output logic [WIDTH-1:0]   view_lo,
    output logic               pending
);

    localparam int RW = res_width(WIDTH);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    acc_mode_e        mode_q;
    logic [RW-1:0]    commit_val;

    // Value the pair takes when the outstanding result lands, wrapping modulo 2^RW.
    always_comb begin
        case (mode_q)
            ADD:     commit_val = {hi_q, lo_q} + res_data;
            SUB:     commit_val = {hi_q, lo_q} - res_data;
            default: commit_val = res_data;
        endcase
    end

    // Read view: with bypass, a read racing the commit observes the accumulated value.
    always_comb begin
        if (BYPASS && commit) begin
            view_hi = commit_val[RW-1:WIDTH];
            view_lo = commit_val[WIDTH-1:0];
        end else begin
            view_hi = hi_q;
            view_lo = lo_q;
        end
    end

    // Pair storage, pending bit and accumulate mode; commit and writes never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            mode_q  <= OVERWRITE;
            pending <= 1'b0;
        end else begin
            if (commit) begin
                {hi_q, lo_q} <= commit_val;
            end else begin
                if (wr_hi) hi_q <= wr_data;
                if (wr_lo) lo_q <= wr_data;
            end
            if (flush || commit) begin
                pending <= 1'b0;
            end else if (issue) begin
                pending <= 1'b1;
                mode_q  <= acc_mode_e'(issue_mode);
            end
        end
    end

endmodule

// File: rtl/hilo_bank.sv
// rtl/hilo_bank.sv - HI/LO accumulator bank top; HILO_BYPASS_EN enables same-cycle read bypass
module hilo_bank
    import hilo_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_ACC = 1,
    parameter int ACC_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [ACC_W-1:0]   req_acc,
    input  logic [1:0]         req_mode,
    input  logic [WIDTH-1:0]   req_data,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    input  logic               res_valid,
    input  logic [ACC_W-1:0]   res_acc,
    input  logic [2*WIDTH-1:0] res_data,
    output logic [NUM_ACC-1:0] pending,
    output logic               protocol_err
);

`ifdef HILO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    hilo_op_e           op;
    logic [WIDTH-1:0]   view_hi [NUM_ACC];
    logic [WIDTH-1:0]   view_lo [NUM_ACC];
    logic [NUM_ACC-1:0] pend_q;
    logic [NUM_ACC-1:0] commit;
    logic               req_pend;
    logic               req_commit;
    logic               res_pend;
    logic               is_read;
    logic               is_update;
    logic               accepted;
    logic [WIDTH-1:0]   rd_src;

    assign op        = hilo_op_e'(req_op);
    assign is_read   = (op == READ_HI) || (op == READ_LO);
    assign is_update = (op == WRITE_HI) || (op == WRITE_LO) || (op == ISSUE);
    assign pending   = pend_q;

    for (genvar g = 0; g < NUM_ACC; g++) begin : g_slot
        logic sel;
        assign sel       = accepted && (req_acc == ACC_W'(g));
        assign commit[g] = res_valid && !flush && pend_q[g] && (res_acc == ACC_W'(g));

        hilo_acc_slot #(
            .WIDTH  (WIDTH),
            .BYPASS (BYPASS)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .issue      (sel && (op == ISSUE)),
            .issue_mode (req_mode),
            .wr_hi      (sel && (op == WRITE_HI)),
            .wr_lo      (sel && (op == WRITE_LO)),
            .wr_data    (req_data),
            .commit     (commit[g]),
            .res_data   (res_data),
            .view_hi    (view_hi[g]),
            .view_lo    (view_lo[g]),
            .pending    (pend_q[g])
        );
    end

    // Look up the request and result targets; out-of-range indices read as idle and zero.
    always_comb begin
        req_pend   = 1'b0;
        req_commit = 1'b0;
        res_pend   = 1'b0;
        rd_src     = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (req_acc == ACC_W'(i)) begin
                req_pend   = pend_q[i];
                req_commit = commit[i];
                rd_src     = (op == READ_HI) ? view_hi[i] : view_lo[i];
            end
            if (res_acc == ACC_W'(i)) begin
                res_pend = pend_q[i];
            end
        end
    end

    // Hold off anything that would observe or clobber a pending pair, except a bypassed read.
    always_comb begin
        req_ready = 1'b1;
        if (req_pend && (is_update || is_read)) begin
            req_ready = BYPASS && is_read && req_commit;
        end
    end

    assign accepted = req_valid && req_ready && !flush;

    // Registered read port and one-cycle pulse for a result nobody was waiting for.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            protocol_err <= 1'b0;
        end else begin
            rd_valid     <= accepted && is_read;
            if (accepted && is_read) begin
                rd_data <= rd_src;
            end
            protocol_err <= res_valid && !flush && !res_pend;
        end
    end

endmodule
